mux_n_1_stream: RTL and testbench

- Parametrised N-to-1 stream multiplexer with valid/ready handshake on every input and on the output.
- Round-robin arbitration selects one valid input per accepted transfer.
- Output is a single registered stage.
- Successor to the combinational 2:1/4:1 muxes; used wherever several producers share one consumer.

---
 rtl/mux_stream_pkg.sv | 29 ++
 rtl/mux_n_1_stream_rr_arbiter.sv | 63 ++++++
 rtl/mux_n_1_stream.sv | 182 ++++++++++++++++++
 tb/tb_mux_n_1_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// ============================================================================
// mux_stream_pkg
// ----------------------------------------------------------------------------
// Shared helpers for the N-to-1 stream multiplexer and its round-robin
// arbiter.
//
// Contents:
//   sel_w(n)         - width of a channel index for n channels, at least 1.
//   wrap_inc(i, n)   - (i + 1) mod n, used for the round-robin pointer.
//   RR_PTR_RESET     - pointer value after reset (channel 0 has top priority).
// ============================================================================
package mux_stream_pkg;

    // Channel 0 is the highest-priority channel after reset.
    localparam int RR_PTR_RESET = 0;

    // A single channel still needs one index bit so that the ports never
    // collapse to zero width.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pointer increment with an explicit wrap from n-1 back to 0. This works
    // for channel counts that are not powers of two.
    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/mux_n_1_stream_rr_arbiter.sv
// ============================================================================
// rr_arbiter
// ----------------------------------------------------------------------------
// Purely combinational round-robin arbiter. Among the asserted request bits,
// it grants the first one found when searching ptr, ptr+1, ... and wrapping
// modulo N_IN.
//
// Parameters:
//   N_IN   - number of requesters (2..16)
//   SEL_W  - width of ptr / grant_idx (derived from N_IN)
//
// Ports:
//   req        in   N_IN    request vector
//   ptr        in   SEL_W   highest-priority requester index (< N_IN)
//   en         in   1       grant enable; when low, grant is all zero
//   grant      out  N_IN    one-hot grant, or zero
//   grant_idx  out  SEL_W   encoded index of the winner
//                           (only meaningful when |grant is set)
// ============================================================================
module rr_arbiter
    import mux_stream_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SEL_W = sel_w(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic             any_req;
    logic [SEL_W-1:0] win_idx;

    // Scan offsets from the farthest to the nearest. The last hit that is
    // written is then the requester closest to ptr in round-robin order, so
    // no priority-encoder chain has to be built explicitly.
    always_comb begin
        int cand;
        any_req = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N_IN;
            if (req[cand]) begin
                any_req = 1'b1;
                win_idx = SEL_W'(cand);
            end
        end
    end

    assign grant_idx = win_idx;

    // The one-hot grant is decoded from the winning index. This makes it
    // impossible for two bits to be set at the same time.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_grant
            assign grant[gi] = en && any_req && (win_idx == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/mux_n_1_stream.sv
// ============================================================================
// mux_n_1_stream
// ----------------------------------------------------------------------------
// N-to-1 stream multiplexer with a valid/ready handshake on every input and on
// the output. A round-robin arbiter picks one valid input per accepted
// transfer. The chosen beat is captured into a single output register.
// Throughput is one beat per cycle, and latency is one cycle from input accept
// to out_valid.
//
// Optional feature (macro MUX_N_1_STREAM_LOCK_EN):
//   Adds packet locking. in_last / out_last are added. After a non-last beat
//   from channel g, only channel g can be granted until its last beat is
//   accepted.
//
// Parameters:
//   N_IN   - number of input channels (2..16)
//   W      - data width (>= 1)
//   SEL_W  - channel index width (derived, do not override)
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   N_IN      per-channel valid
//   in_data    in   N_IN*W    channel i on bits [i*W +: W]
//   in_last    in   N_IN      per-channel end of packet (LOCK_EN only)
//   in_ready   out  N_IN      per-channel ready, one-hot or zero
//   out_valid  out  1         output register holds a beat
//   out_data   out  W         registered data
//   out_sel    out  SEL_W     channel that supplied out_data
//   out_last   out  1         registered end of packet (LOCK_EN only)
//   out_ready  in   1         consumer ready
// ============================================================================
module mux_n_1_stream
    import mux_stream_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int W     = 4,
    parameter int SEL_W = sel_w(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   in_valid,
    input  logic [N_IN*W-1:0] in_data,
`ifdef MUX_N_1_STREAM_LOCK_EN
    input  logic [N_IN-1:0]   in_last,
    output logic              out_last,
`endif
    output logic [N_IN-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel,
    input  logic              out_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             out_valid_reg;
    logic [W-1:0]     out_data_reg;
    logic [SEL_W-1:0] out_sel_reg;
    logic [SEL_W-1:0] rr_ptr_reg;
    logic [SEL_W-1:0] rr_ptr_next;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             stage_free;
    logic             grant_en;
    logic [N_IN-1:0]  arb_req;
    logic [N_IN-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer_in;
    logic             xfer_out;
    logic [W-1:0]     grant_data;

    // The stage can take a new beat when it is empty or is being drained in
    // this same cycle. out_ready therefore reaches in_ready combinationally.
    // Gating with rst_n keeps every in_ready low while reset is asserted,
    // even though the output register is already empty at that point.
    assign stage_free = !out_valid_reg || out_ready;
    assign grant_en   = rst_n && stage_free;

`ifdef MUX_N_1_STREAM_LOCK_EN
    logic             lock_active_reg;
    logic [SEL_W-1:0] lock_idx_reg;
    logic [N_IN-1:0]  lock_mask;
    logic             out_last_reg;

    // While a packet is in flight, only the owning channel may request.
    // The arbiter then grants it no matter where the pointer is.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_lock_mask
            assign lock_mask[gi] = !lock_active_reg || (lock_idx_reg == SEL_W'(gi));
        end
    endgenerate

    assign arb_req = in_valid & lock_mask;
`else
    assign arb_req = in_valid;
`endif

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr_reg),
        .en        (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A grant is only produced for a valid request. For that reason, any set
    // grant bit means that an input transfer happens in this cycle.
    assign in_ready   = grant;
    assign xfer_in    = |grant;
    assign xfer_out   = out_valid_reg && out_ready;
    assign grant_data = in_data[int'(grant_idx)*W +: W];

    // ------------------------------------------------------------------
    // Pointer update
    // ------------------------------------------------------------------
    // The pointer moves only on an accepted beat. With locking, it moves only
    // on an accepted last beat. The lock keeps the owner selected
    // independently of the pointer anyway.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (xfer_in) begin
`ifdef MUX_N_1_STREAM_LOCK_EN
            if (in_last[grant_idx]) begin
                rr_ptr_next = SEL_W'(wrap_inc(int'(grant_idx), N_IN));
            end
`else
            rr_ptr_next = SEL_W'(wrap_inc(int'(grant_idx), N_IN));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= SEL_W'(RR_PTR_RESET);
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (xfer_in) begin
                // This also covers a simultaneous drain and reload. In that
                // case the register is refilled with no bubble.
                out_valid_reg <= 1'b1;
                out_data_reg  <= grant_data;
                out_sel_reg   <= grant_idx;
            end else if (xfer_out) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef MUX_N_1_STREAM_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active_reg <= 1'b0;
            lock_idx_reg    <= '0;
            out_last_reg    <= 1'b0;
        end else if (xfer_in) begin
            out_last_reg    <= in_last[grant_idx];
            lock_active_reg <= !in_last[grant_idx];
            lock_idx_reg    <= grant_idx;
        end
    end

    assign out_last = out_last_reg;
`endif

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Directed test bench for mux_n_1_stream (N_IN=4, W=4).
// The stimulus process pushes the expected output beats into a scoreboard
// queue. A monitor pops one entry and compares it against each output transfer.
module tb_mux_n_1_stream;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;
`ifdef MUX_N_1_STREAM_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
`endif

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] sel;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    mux_n_1_stream #(.N_IN(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef MUX_N_1_STREAM_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [1:0] s, input logic l);
        exp_t e;
        e.data = d;
        e.sel  = s;
        e.last = l;
        sb_q.push_back(e);
    endtask

    task automatic set_data(input int ch, input logic [3:0] v);
        in_data[ch*W +: W] = v;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (2) tick();
    endtask

    // Monitor: each output transfer is sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got sel=%0d data=%h, required no output", out_sel, out_data);
                end else begin
                    e = sb_q.pop_front();
                    $display("beat sel=%0d data=%h (expect sel=%0d data=%h)", out_sel, out_data, e.sel, e.data);
                    check("beat_data", 32'(out_data), 32'(e.data));
                    check("beat_sel", 32'(out_sel), 32'(e.sel));
`ifdef MUX_N_1_STREAM_LOCK_EN
                    check("beat_last", 32'(out_last), 32'(e.last));
`endif
                end
            end
        end
    end

    initial begin
        // ---------------- reset ----------------
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        in_data   = '0;
        for (int i = 0; i < N; i++) set_data(i, 4'(4'hA + i));
`ifdef MUX_N_1_STREAM_LOCK_EN
        in_last = 4'hF;
`endif
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // ---------- all channels valid, full throughput ----------
        push(4'hA, 2'd0, 1'b1);
        push(4'hB, 2'd1, 1'b1);
        push(4'hC, 2'd2, 1'b1);
        push(4'hD, 2'd3, 1'b1);
        push(4'hA, 2'd0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_out_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // ---------- only ch2 valid, 5 beats (pointer = 1) ----------
        in_valid = 4'b0100;
        set_data(2, 4'h7);
        for (int i = 0; i < 5; i++) push(4'h7, 2'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ch2_out_valid", 32'(out_valid), 32'd1);
            check("ch2_in_ready", 32'(in_ready), 32'h4);
        end
        drain();

        // ---------- backpressure (pointer = 3) ----------
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        set_data(1, 4'h5);
        push(4'h5, 2'd1, 1'b1);
        tick();
        in_valid = 4'b0001;
        set_data(0, 4'h9);
        push(4'h9, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'h5);
            check("stall_out_sel", 32'(out_sel), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = '0;
        check("release_out_sel", 32'(out_sel), 32'd0);
        check("release_out_data", 32'(out_data), 32'h9);
        drain();

        // ---------- simultaneous drain/reload on ch3 (pointer = 1) ----------
        in_valid = 4'b1000;
        set_data(3, 4'hE);
        push(4'hE, 2'd3, 1'b1);
        push(4'hF, 2'd3, 1'b1);
        tick();
        check("simul_out_data0", 32'(out_data), 32'hE);
        set_data(3, 4'hF);
        tick();
        check("simul_out_valid", 32'(out_valid), 32'd1);
        check("simul_out_data1", 32'(out_data), 32'hF);
        in_valid = '0;
        tick();
        check("simul_drained", 32'(out_valid), 32'd0);

        // ---------- asynchronous reset mid-stream (pointer = 0) ----------
        in_valid  = 4'hF;
        for (int i = 0; i < N; i++) set_data(i, 4'(4'hA + i));
        out_ready = 1'b0;
        tick();
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        tick();
        tick();
        out_ready = 1'b1;
        push(4'hA, 2'd0, 1'b1);
        push(4'hB, 2'd1, 1'b1);
        rst_n = 1'b1;
        tick();
        check("post_rst_sel0", 32'(out_sel), 32'd0);
        tick();
        in_valid = '0;
        check("post_rst_sel1", 32'(out_sel), 32'd1);
        drain();

`ifdef MUX_N_1_STREAM_LOCK_EN
        // ---------- packet lock: ch0 three beats, ch1 waiting (pointer = 2) ----------
        in_valid = 4'b0011;
        in_last  = 4'b0010;
        set_data(0, 4'h1);
        set_data(1, 4'h8);
        push(4'h1, 2'd0, 1'b0);
        push(4'h2, 2'd0, 1'b0);
        push(4'h3, 2'd0, 1'b1);
        push(4'h8, 2'd1, 1'b1);
        tick();
        check("lock_in_ready", 32'(in_ready), 32'h1);
        set_data(0, 4'h2);
        tick();
        set_data(0, 4'h3);
        in_last = 4'b0011;
        tick();
        in_valid = 4'b0010;
        tick();
        in_valid = '0;
        in_last  = 4'hF;
        drain();
`endif

        tick();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
